instr_decoder_pipe: RTL and testbench



---
 rtl/instr_decoder_pipe_if.sv | 26 ++
 rtl/instr_decoder_pipe.sv | 108 ++++++++++
 tb/tb_instr_decoder_pipe.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/instr_decoder_pipe_if.sv
// rtl/instr_decoder_pipe_if.sv - instruction-in / decoded-out stream bundle for instr_decoder_pipe
// master drives words and out_ready; slave (the decoder) drives in_ready and the decoded fields.
interface instr_decoder_pipe_if #(
  parameter int INSTR_W = 8,
  parameter int OPC_W   = 3
);
  logic [INSTR_W-1:0] in_word;
  logic               in_valid;
  logic               in_ready;
  logic               dec_acc_sel;
  logic [OPC_W-1:0]   dec_opcode;
  logic [INSTR_W-1:0] dec_imm;
  logic               dec_ext;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output in_word, in_valid, out_ready,
    input  in_ready, dec_acc_sel, dec_opcode, dec_imm, dec_ext, out_valid
  );

  modport slave (
    input  in_word, in_valid, out_ready,
    output in_ready, dec_acc_sel, dec_opcode, dec_imm, dec_ext, out_valid
  );
endinterface

// File: rtl/instr_decoder_pipe.sv
// rtl/instr_decoder_pipe.sv - registered two-state instruction decoder with extended-immediate assembly
// Define DECODER_SIGNEXT_EN to sign-extend the short immediate; otherwise it is zero-extended.
module instr_decoder_pipe #(
  parameter int               INSTR_W = 8,
  parameter int               OPC_W   = 3,
  parameter logic [OPC_W-1:0] EXT_OPC = {OPC_W{1'b1}},
  parameter int               COUNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  instr_decoder_pipe_if.slave  bus,
  output logic [COUNT_W-1:0]   instr_count
);
  localparam int IMM_W = INSTR_W - 1 - OPC_W;

  typedef enum logic { S_FETCH, S_EXT } state_t;

  state_t             state;
  logic               hold_acc_sel;
  logic [OPC_W-1:0]   hold_opcode;
  logic               out_valid_q;
  logic               acc_sel_q;
  logic [OPC_W-1:0]   opcode_q;
  logic [INSTR_W-1:0] imm_q;
  logic               ext_q;
  logic [COUNT_W-1:0] count_q;

  logic               word_acc_sel;
  logic [OPC_W-1:0]   word_opcode;
  logic [INSTR_W-1:0] short_imm;
  logic               ready;
  logic               accept;
  logic               handoff;

  assign word_acc_sel = bus.in_word[INSTR_W-1];
  assign word_opcode  = bus.in_word[INSTR_W-2:IMM_W];

`ifdef DECODER_SIGNEXT_EN
  assign short_imm = {{(INSTR_W-IMM_W){bus.in_word[IMM_W-1]}}, bus.in_word[IMM_W-1:0]};
`else
  assign short_imm = {{(INSTR_W-IMM_W){1'b0}}, bus.in_word[IMM_W-1:0]};
`endif

  // Output register either empty or draining this cycle lets a new word in.
  assign ready   = !flush && (!out_valid_q || bus.out_ready);
  assign accept  = bus.in_valid && ready;
  assign handoff = out_valid_q && bus.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_FETCH;
      hold_acc_sel <= 1'b0;
      hold_opcode  <= '0;
      out_valid_q  <= 1'b0;
      acc_sel_q    <= 1'b0;
      opcode_q     <= '0;
      imm_q        <= '0;
      ext_q        <= 1'b0;
      count_q      <= '0;
    end else if (flush) begin
      // Decoded data is left in place; only validity and the partial instruction go.
      state        <= S_FETCH;
      hold_acc_sel <= 1'b0;
      hold_opcode  <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      if (handoff) begin
        out_valid_q <= 1'b0;
        count_q     <= count_q + 1'b1;
      end
      if (accept) begin
        case (state)
          S_FETCH: begin
            if (word_opcode == EXT_OPC) begin
              hold_acc_sel <= word_acc_sel;
              hold_opcode  <= word_opcode;
              state        <= S_EXT;
            end else begin
              acc_sel_q   <= word_acc_sel;
              opcode_q    <= word_opcode;
              imm_q       <= short_imm;
              ext_q       <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
          S_EXT: begin
            acc_sel_q   <= hold_acc_sel;
            opcode_q    <= hold_opcode;
            imm_q       <= bus.in_word;
            ext_q       <= 1'b1;
            out_valid_q <= 1'b1;
            state       <= S_FETCH;
          end
          default: state <= S_FETCH;
        endcase
      end
    end
  end

  assign bus.in_ready    = ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.dec_acc_sel = acc_sel_q;
  assign bus.dec_opcode  = opcode_q;
  assign bus.dec_imm     = imm_q;
  assign bus.dec_ext     = ext_q;
  assign instr_count     = count_q;
endmodule

// File: tb/tb_instr_decoder_pipe.sv
// tb/tb_instr_decoder_pipe.sv - directed self-checking bench for instr_decoder_pipe
// Runs with COUNT_W=2 so counter wrap is reached quickly.
module tb_instr_decoder_pipe;
  localparam int INSTR_W = 8;
  localparam int OPC_W   = 3;
  localparam int COUNT_W = 2;

  logic               clk;
  logic               reset;
  logic               flush;
  logic [COUNT_W-1:0] instr_count;
  int                 checks;
  int                 failures;

  instr_decoder_pipe_if #(.INSTR_W(INSTR_W), .OPC_W(OPC_W)) bus ();

  instr_decoder_pipe #(
    .INSTR_W(INSTR_W),
    .OPC_W  (OPC_W),
    .COUNT_W(COUNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .bus        (bus.slave),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_signext;
    checks   = 0;
    failures = 0;
`ifdef DECODER_SIGNEXT_EN
    exp_signext = 8'hFC;
`else
    exp_signext = 8'h0C;
`endif
    reset         = 1'b1;
    flush         = 1'b0;
    bus.in_word   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_acc_sel",   32'(bus.dec_acc_sel), 0);
    chk("rst_opcode",    32'(bus.dec_opcode), 0);
    chk("rst_imm",       32'(bus.dec_imm), 0);
    chk("rst_ext",       32'(bus.dec_ext), 0);
    chk("rst_count",     32'(instr_count), 0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready",  32'(bus.in_ready), 1);

    // Short instruction A5
    bus.in_word = 8'hA5; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick();
    chk("a5_valid",   32'(bus.out_valid), 1);
    chk("a5_acc_sel", 32'(bus.dec_acc_sel), 1);
    chk("a5_opcode",  32'(bus.dec_opcode), 3'b010);
    chk("a5_imm",     32'(bus.dec_imm), 8'h05);
    chk("a5_ext",     32'(bus.dec_ext), 0);
    chk("a5_count0",  32'(instr_count), 0);
    bus.in_valid = 1'b0;
    tick();
    chk("a5_count1",  32'(instr_count), 1);
    chk("a5_drained", 32'(bus.out_valid), 0);

    // Extended 7F + C3
    bus.in_word = 8'h7F; bus.in_valid = 1'b1;
    tick();
    chk("ext_no_out", 32'(bus.out_valid), 0);
    bus.in_word = 8'hC3;
    tick();
    chk("ext_valid",   32'(bus.out_valid), 1);
    chk("ext_acc_sel", 32'(bus.dec_acc_sel), 0);
    chk("ext_opcode",  32'(bus.dec_opcode), 3'b111);
    chk("ext_imm",     32'(bus.dec_imm), 8'hC3);
    chk("ext_flag",    32'(bus.dec_ext), 1);
    bus.in_valid = 1'b0;
    tick();
    chk("ext_count",   32'(instr_count), 2);

    // Backpressure: 34 held, 21 waiting
    bus.out_ready = 1'b0; bus.in_word = 8'h34; bus.in_valid = 1'b1;
    tick();
    chk("bp_load_imm", 32'(bus.dec_imm), 8'h04);
    bus.in_word = 8'h21;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", 32'(bus.in_ready), 0);
      chk("bp_valid",    32'(bus.out_valid), 1);
      chk("bp_opcode",   32'(bus.dec_opcode), 3'b011);
      chk("bp_imm",      32'(bus.dec_imm), 8'h04);
      tick();
    end
    chk("bp_count_held", 32'(instr_count), 2);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus.in_ready), 1);
    tick();
    chk("bp_new_valid",  32'(bus.out_valid), 1);
    chk("bp_new_opcode", 32'(bus.dec_opcode), 3'b010);
    chk("bp_new_imm",    32'(bus.dec_imm), 8'h01);
    chk("bp_count3",     32'(instr_count), 3);
    bus.in_valid = 1'b0;
    tick();
    chk("wrap_count0",   32'(instr_count), 0);

    // Flush while in S_EXT
    bus.in_word = 8'hFA; bus.in_valid = 1'b1;
    tick();
    chk("fl_ext_no_out", 32'(bus.out_valid), 0);
    bus.in_valid = 1'b0; flush = 1'b1;
    #1;
    chk("fl_in_ready", 32'(bus.in_ready), 0);
    tick();
    flush = 1'b0;
    bus.in_word = 8'h12; bus.in_valid = 1'b1;
    tick();
    chk("fl_valid",  32'(bus.out_valid), 1);
    chk("fl_opcode", 32'(bus.dec_opcode), 3'b001);
    chk("fl_imm",    32'(bus.dec_imm), 8'h02);
    chk("fl_ext",    32'(bus.dec_ext), 0);
    chk("fl_acc",    32'(bus.dec_acc_sel), 0);
    bus.in_valid = 1'b0;
    tick();
    chk("wrap_count1", 32'(instr_count), 1);

    // Short immediate extension, then flush coinciding with handoff
    bus.out_ready = 1'b0; bus.in_word = 8'h0C; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("sx_imm", 32'(bus.dec_imm), 32'(exp_signext));
    bus.out_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flh_valid",    32'(bus.out_valid), 0);
    chk("flh_count",    32'(instr_count), 1);
    chk("flh_imm_kept", 32'(bus.dec_imm), 32'(exp_signext));

    // Async reset mid extended instruction
    bus.out_ready = 1'b0; bus.in_word = 8'h55; bus.in_valid = 1'b1;
    tick();
    bus.out_ready = 1'b1; bus.in_word = 8'h7F;
    tick();
    bus.in_valid = 1'b0;
    chk("ar_pre_count",  32'(instr_count), 2);
    chk("ar_pre_opcode", 32'(bus.dec_opcode), 3'b101);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_count",  32'(instr_count), 0);
    chk("ar_opcode", 32'(bus.dec_opcode), 0);
    chk("ar_imm",    32'(bus.dec_imm), 0);
    chk("ar_valid",  32'(bus.out_valid), 0);
    tick();
    reset = 1'b0;
    bus.in_word = 8'hC3; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("ar_post_valid",  32'(bus.out_valid), 1);
    chk("ar_post_ext",    32'(bus.dec_ext), 0);
    chk("ar_post_opcode", 32'(bus.dec_opcode), 3'b100);
    chk("ar_post_imm",    32'(bus.dec_imm), 8'h03);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
